ram_tick_bank: RTL and testbench

- Parametrised single-port synchronous RAM bank with a built-in rate-strobe generator and a valid/ready request interface.
- Successor to the fixed 128x8 divided-clock RAM.
- Everything runs on clk. The divider produces a one-cycle enable tick, not a derived clock.
- Adds byte enables, a post-reset zero-clear sweep, and a registered read-response handshake.

---
 rtl/ram_tick_pkg.sv | 32 +++
 rtl/ram_tick_gen.sv | 52 +++++
 rtl/ram_tick_bank.sv | 165 ++++++++++++++++
 tb/tb_ram_tick_bank.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_tick_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_tick_pkg
// Purpose  : Shared types and sizing helpers for the ram_tick_bank block.
//            - state_t       : bank control states (CLEAR sweep, RUN)
//            - calc_depth    : words in the array for a given address width
//            - calc_be_w     : byte-enable lanes for a given data width
//            - calc_cnt_w    : divider counter width, never below 1 bit
// Revision : 1.0 - initial release
// ============================================================================
package ram_tick_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int calc_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // A divide-by-1 divider still needs a 1-bit register to hold its constant 0.
  function automatic int calc_cnt_w(input int div_max);
    return (div_max > 1) ? $clog2(div_max) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ram_tick_gen
// Purpose  : Free-running rate-strobe generator. Emits a one-cycle enable
//            pulse every DIV_MAX clk cycles; never produces a derived clock.
// Ports    : clk  in  - clock, rising edge
//            rst  in  - synchronous active-high reset
//            tick out - one-cycle strobe, high while count == DIV_MAX-1
// Revision : 1.0 - initial release
// ============================================================================
module ram_tick_gen
  import ram_tick_pkg::*;
#(
  parameter int DIV_MAX = 2**26
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               CNT_W = calc_cnt_w(DIV_MAX);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV_MAX - 1);

  generate
    if (DIV_MAX < 1) begin : g_bad_div_max
      $error("ram_tick_gen: DIV_MAX must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] count;
  // Suppresses the strobe in the first cycle out of reset; only matters for
  // DIV_MAX == 1, where the counter sits at LAST permanently.
  logic             started;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign tick = started && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ram_tick_bank.sv
`default_nettype none
// ============================================================================
// Module   : ram_tick_bank
// Purpose  : Single-port synchronous RAM bank paced by an internal rate
//            strobe. After reset the array is swept to zero, then one
//            request may transfer per tick over a valid/ready interface.
//            Reads (and, with WR_RSP=1, writes) answer one clk later.
// Ports    : clk        in  - clock, rising edge
//            rst        in  - synchronous active-high reset
//            req_valid  in  - request present
//            req_ready  out - request accepted this cycle (tick in RUN)
//            req_we     in  - 1 write, 0 read
//            req_be     in  - per-byte write enables
//            req_addr   in  - word address
//            req_wdata  in  - write data
//            rsp_valid  out - one-cycle response strobe
//            rsp_data   out - response word, held until the next response
//            tick_o     out - one-cycle rate strobe
//            clr_busy   out - zero-clear sweep in progress
// Revision : 1.0 - initial release
// ============================================================================
module ram_tick_bank
  import ram_tick_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 7,
  parameter int DIV_MAX = 2**26,
  parameter bit WR_RSP  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                tick_o,
  output logic                clr_busy
);

  localparam int DEPTH = calc_depth(ADDR_W);
  localparam int BE_W  = calc_be_w(DATA_W);

  generate
    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("ram_tick_bank: DATA_W must be a positive multiple of 8");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic              tick;

  // Single memory port, shared between the sweep and the request path.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              rsp_load;
  logic              rsp_valid_q;

  ram_tick_gen #(
    .DIV_MAX (DIV_MAX)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign tick_o = tick;

  // --------------------------------------------------------------------------
  // State register and sweep pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      // Wraps back to 0 after the last word, ready for the next sweep.
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and port control
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    clr_busy   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = req_addr;
    mem_be     = req_be;
    mem_wdata  = req_wdata;
    rsp_load   = 1'b0;

    case (state)
      CLEAR: begin
        clr_busy  = 1'b1;
        // The sweep runs every clk, independent of the tick.
        mem_we    = !rst;
        mem_addr  = clr_ptr;
        mem_be    = '1;
        mem_wdata = '0;
        if (clr_ptr == '1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Gating with rst keeps a transfer from being acknowledged on an
        // edge that the reset will discard.
        req_ready = tick && !rst;
        mem_we    = req_valid && req_ready && req_we;
        rsp_load  = req_valid && req_ready && (!req_we || WR_RSP);
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory array: byte-lane writes, no reset (the sweep zeroes it)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response register. Sampling mem on the same edge as a write yields the
  // pre-write word, which is the read-first value WR_RSP returns.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rsp_valid_q <= rsp_load;
      if (rsp_load) begin
        rsp_data <= mem[mem_addr];
      end
    end
  end

  // A reset raised while a response is on the port drops it immediately.
  assign rsp_valid = rsp_valid_q && !rst;

endmodule
`default_nettype wire

// File: tb/tb_ram_tick_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ram_tick_bank
// Purpose  : Self-checking bench for ram_tick_bank. Two instances:
//            A: DATA_W=16 ADDR_W=4 DIV_MAX=3 WR_RSP=0
//            B: DATA_W=8  ADDR_W=3 DIV_MAX=4 WR_RSP=1
//            Expected values come from array models and a cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_tick_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid = 1'b0, a_ready, a_we = 1'b0;
  logic [1:0]  a_be = '0;
  logic [3:0]  a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic        a_rsp_valid, a_tick, a_clr_busy;
  logic [15:0] a_rsp_data;

  logic        b_valid = 1'b0, b_ready, b_we = 1'b0;
  logic [0:0]  b_be = '0;
  logic [2:0]  b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        b_rsp_valid, b_tick, b_clr_busy;
  logic [7:0]  b_rsp_data;

  ram_tick_bank #(.DATA_W(16), .ADDR_W(4), .DIV_MAX(3), .WR_RSP(1'b0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_be(a_be), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data), .tick_o(a_tick), .clr_busy(a_clr_busy));

  ram_tick_bank #(.DATA_W(8), .ADDR_W(3), .DIV_MAX(4), .WR_RSP(1'b1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_be(b_be), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data), .tick_o(b_tick), .clr_busy(b_clr_busy));

  int total = 0;
  int bad = 0;
  int cyc = 0;               // cycles since the last reset edge
  logic [15:0] model_a [16];
  logic [7:0]  model_b [8];
  logic [15:0] last_a;       // what rsp_data on A should be holding
  logic [7:0]  last_b;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [15:0] merge16(logic [15:0] old, logic [15:0] nw, logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  // One transfer on A; returns the response port as seen the cycle after accept.
  task automatic op_a(input logic we, input logic [1:0] be, input logic [3:0] ad,
                      input logic [15:0] wd, output logic rv, output logic [15:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    a_valid = 1'b1; a_we = we; a_be = be; a_addr = ad; a_wdata = wd;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    if (!a_ready) begin
      total++; bad++;
      $display("FAIL op_a_timeout addr=%0d: ready=%b, required 1 within 50 cycles", ad, a_ready);
      a_valid = 1'b0; rv = 1'b0; rd = 'x;
      return;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    rv = a_rsp_valid; rd = a_rsp_data;
  endtask

  task automatic op_b(input logic we, input logic [2:0] ad, input logic [7:0] wd,
                      output logic rv, output logic [7:0] rd);
    int n;
    n = 0;
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = we; b_be = 1'b1; b_addr = ad; b_wdata = wd;
    @(negedge clk);
    while (!b_ready && n < 50) begin @(negedge clk); n++; end
    if (!b_ready) begin
      total++; bad++;
      $display("FAIL op_b_timeout addr=%0d: ready=%b, required 1 within 50 cycles", ad, b_ready);
      b_valid = 1'b0; rv = 1'b0; rd = 'x;
      return;
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    rv = b_rsp_valid; rd = b_rsp_data;
  endtask

  // Holds rst for two edges, checks reset outputs and the sweep length.
  task automatic test_reset;
    int na, nb, n;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (a_ready !== 1'b0 || a_rsp_valid !== 1'b0 || a_rsp_data !== 16'h0 ||
        a_tick !== 1'b0 || a_clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_a: ready=%b rv=%b rd=%h tick=%b busy=%b, required 0 0 0000 0 1",
               a_ready, a_rsp_valid, a_rsp_data, a_tick, a_clr_busy);
    end
    total++;
    if (b_ready !== 1'b0 || b_rsp_valid !== 1'b0 || b_rsp_data !== 8'h0 ||
        b_tick !== 1'b0 || b_clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_b: ready=%b rv=%b rd=%h tick=%b busy=%b, required 0 0 00 0 1",
               b_ready, b_rsp_valid, b_rsp_data, b_tick, b_clr_busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    na = 0; nb = 0; n = 0;
    @(negedge clk);
    while ((a_clr_busy || b_clr_busy) && n < 200) begin
      if (a_clr_busy) na++;
      if (b_clr_busy) nb++;
      n++;
      @(negedge clk);
    end
    total++;
    if (na != 16) begin bad++; $display("FAIL sweep_len_a: busy cycles=%0d, required 16", na); end
    total++;
    if (nb != 8) begin bad++; $display("FAIL sweep_len_b: busy cycles=%0d, required 8", nb); end
    for (int i = 0; i < 16; i++) model_a[i] = 16'h0;
    for (int i = 0; i < 8; i++)  model_b[i] = 8'h0;
    last_a = 16'h0; last_b = 8'h0;
  endtask

  task automatic test_read_all;
    logic rv; logic [15:0] rd; logic [7:0] rdb;
    for (int i = 0; i < 16; i++) begin
      op_a(1'b0, 2'b00, 4'(i), 16'h0, rv, rd);
      total++;
      if (rv !== 1'b1 || rd !== model_a[i]) begin
        bad++;
        $display("FAIL read_all_a addr=%0d: valid=%b data=%h, required 1 %h", i, rv, rd, model_a[i]);
      end
      last_a = model_a[i];
    end
    for (int i = 0; i < 8; i++) begin
      op_b(1'b0, 3'(i), 8'h0, rv, rdb);
      total++;
      if (rv !== 1'b1 || rdb !== model_b[i]) begin
        bad++;
        $display("FAIL read_all_b addr=%0d: valid=%b data=%h, required 1 %h", i, rv, rdb, model_b[i]);
      end
      last_b = model_b[i];
    end
  endtask

  task automatic test_byte_enable;
    logic rv; logic [15:0] rd;
    logic [1:0]  bes [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    logic [15:0] wds [5] = '{16'hBEEF, 16'h1234, 16'hFFFF, 16'h77AA, 16'h0F0F};
    for (int k = 0; k < 5; k++) begin
      op_a(1'b1, bes[k], 4'd5, wds[k], rv, rd);
      total++;
      if (rv !== 1'b0 || rd !== last_a) begin
        bad++;
        $display("FAIL be_write k=%0d: valid=%b data=%h, required 0 %h", k, rv, rd, last_a);
      end
      model_a[5] = merge16(model_a[5], wds[k], bes[k]);
      op_a(1'b0, 2'b00, 4'd5, 16'h0, rv, rd);
      total++;
      if (rv !== 1'b1 || rd !== model_a[5]) begin
        bad++;
        $display("FAIL be_read k=%0d: valid=%b data=%h, required 1 %h", k, rv, rd, model_a[5]);
      end
      last_a = model_a[5];
    end
  endtask

  task automatic test_wr_rsp;
    logic rv; logic [7:0] rd;
    logic [7:0] wds [3] = '{8'h0A, 8'h55, 8'hC3};
    for (int k = 0; k < 3; k++) begin
      op_b(1'b1, 3'd2, wds[k], rv, rd);
      total++;
      if (rv !== 1'b1 || rd !== model_b[2]) begin
        bad++;
        $display("FAIL wr_rsp k=%0d: valid=%b data=%h, required 1 %h", k, rv, rd, model_b[2]);
      end
      model_b[2] = wds[k];
      op_b(1'b0, 3'd2, 8'h0, rv, rd);
      total++;
      if (rv !== 1'b1 || rd !== model_b[2]) begin
        bad++;
        $display("FAIL wr_rsp_read k=%0d: valid=%b data=%h, required 1 %h", k, rv, rd, model_b[2]);
      end
    end
    last_b = model_b[2];
  endtask

  // req_valid held high on B: ready and tick follow cycle position only.
  task automatic test_tick_gating;
    logic exp_b, exp_a, prev_b;
    int nrdy;
    prev_b = 1'b0; nrdy = 0;
    @(posedge clk); #1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 3'd2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_b = (cyc % 4) == 3;
      exp_a = (cyc % 3) == 2;
      total++;
      if (b_ready !== exp_b || b_tick !== exp_b) begin
        bad++;
        $display("FAIL tick_b k=%0d: ready=%b tick=%b, required %b", k, b_ready, b_tick, exp_b);
      end
      total++;
      if (a_tick !== exp_a) begin
        bad++;
        $display("FAIL tick_a k=%0d: tick=%b, required %b", k, a_tick, exp_a);
      end
      total++;
      if (b_rsp_valid !== prev_b || (prev_b && b_rsp_data !== model_b[2])) begin
        bad++;
        $display("FAIL gated_rsp k=%0d: valid=%b data=%h, required %b %h", k, b_rsp_valid,
                 b_rsp_data, prev_b, model_b[2]);
      end
      if (b_ready === 1'b1) nrdy++;
      prev_b = exp_b;
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (nrdy != 4) begin bad++; $display("FAIL accept_count: accepts=%0d, required 4", nrdy); end
  endtask

  task automatic test_random(int n);
    logic rv; logic [15:0] rd; logic [7:0] rdb;
    logic we; logic [1:0] be; logic [3:0] ad; logic [15:0] wd; logic [2:0] adb;
    for (int k = 0; k < n; k++) begin
      we = 1'($urandom_range(0, 1)); be = 2'($urandom_range(0, 3));
      ad = 4'($urandom_range(0, 15)); wd = 16'($urandom);
      op_a(we, be, ad, wd, rv, rd);
      total++;
      if (we) begin
        if (rv !== 1'b0 || rd !== last_a) begin
          bad++;
          $display("FAIL rand_a_wr k=%0d: valid=%b data=%h, required 0 %h", k, rv, rd, last_a);
        end
        model_a[ad] = merge16(model_a[ad], wd, be);
      end else begin
        if (rv !== 1'b1 || rd !== model_a[ad]) begin
          bad++;
          $display("FAIL rand_a_rd k=%0d: valid=%b data=%h, required 1 %h", k, rv, rd, model_a[ad]);
        end
        last_a = model_a[ad];
      end
      adb = 3'($urandom_range(0, 7));
      op_b(we, adb, wd[7:0], rv, rdb);
      total++;
      if (rv !== 1'b1 || rdb !== model_b[adb]) begin
        bad++;
        $display("FAIL rand_b k=%0d we=%b: valid=%b data=%h, required 1 %h", k, we, rv, rdb, model_b[adb]);
      end
      last_b = model_b[adb];
      if (we) model_b[adb] = wd[7:0];
    end
  endtask

  task automatic test_reset_mid_op;
    logic rv; logic [15:0] rd; logic [7:0] rdb;
    int n;
    op_a(1'b1, 2'b11, 4'd7, 16'hA5A5, rv, rd);
    model_a[7] = 16'hA5A5;
    op_b(1'b1, 3'd4, 8'h3C, rv, rdb);
    model_b[4] = 8'h3C;
    n = 0;
    @(posedge clk); #1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd7;
    @(negedge clk);
    while (!a_ready && n < 50) begin @(negedge clk); n++; end
    total++;
    if (!a_ready) begin bad++; $display("FAIL mid_reset_accept: ready=%b, required 1", a_ready); end
    @(posedge clk); #1;
    a_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if (a_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_rsp: valid=%b, required 0", a_rsp_valid);
    end
    test_reset();
    test_read_all();
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_byte_enable();
    test_wr_rsp();
    test_tick_gating();
    test_random(30);
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
